// File: rtl/memory_stage_pkg.sv
// Shared types for the MEM stage of the RV64 core: execute/memory bundles,
// data-bus request/response, access size and MEM FSM encodings.
package memory_stage_pkg;

  localparam int XLEN  = 64;        // data/address width in bits
  localparam int BYTES = XLEN / 8;  // bus byte lanes (strobe width)

  typedef logic [XLEN-1:0]  word_t;
  typedef logic [BYTES-1:0] strobe_t;

  // Access size as carried in ctl.memSize (log2 of the byte count).
  typedef enum logic [1:0] {
    MSIZE1 = 2'b00,
    MSIZE2 = 2'b01,
    MSIZE4 = 2'b10,
    MSIZE8 = 2'b11
  } msize_t;

  // MEM stage sequencing.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic   regWrite;
    logic   memRead;
    logic   memWrite;
    msize_t memSize;
    logic   memUnsigned;
  } control_t;

  // Bundle from execute. rd is the destination register index here.
  typedef struct packed {
    word_t       alu_out;    // effective address for loads/stores
    word_t       pc;
    word_t       sextimm;
    word_t       storedata;
    logic [4:0]  rd;
    control_t    ctl;
  } execute_data_t;

  // Bundle to writeback. rd carries the load result; dst is the register index.
  typedef struct packed {
    word_t       alu_out;
    word_t       pc;
    word_t       sextimm;
    word_t       rd;
    logic [4:0]  dst;
    control_t    ctl;
    logic        misaligned;
  } memory_data_t;

  typedef struct packed {
    logic    valid;
    word_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  // Lane mask of an access of the given size starting at lane 0.
  function automatic strobe_t size_mask(input msize_t size);
    strobe_t mask;
    case (size)
      MSIZE1:  mask = strobe_t'(8'h01);
      MSIZE2:  mask = strobe_t'(8'h03);
      MSIZE4:  mask = strobe_t'(8'h0F);
      default: mask = strobe_t'(8'hFF);
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/memory_stage_align.sv
// mem_align: purely combinational lane steering for the MEM stage.
// Produces store strobe/data, the formatted load result and the
// misalignment flag from the low address bits and the access size.
module mem_align
  import memory_stage_pkg::*;
(
  input  logic [2:0]       addr_off,     // low address bits (byte offset in the bus word)
  input  msize_t           size,
  input  logic             is_unsigned,
  input  logic [XLEN-1:0]  storedata,
  input  logic [XLEN-1:0]  rdata,
  output logic [BYTES-1:0] strobe,
  output logic [XLEN-1:0]  wdata,
  output logic [XLEN-1:0]  load_result,
  output logic             misaligned
);

  logic [5:0]      bit_off;
  logic [XLEN-1:0] shifted;

  assign bit_off = {addr_off, 3'b000};
  assign strobe  = size_mask(size) << addr_off;
  assign wdata   = storedata << bit_off;
  assign shifted = rdata >> bit_off;

  // Natural alignment: the offset must be a multiple of the access size.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    misaligned = 1'b0;
    case (size)
      MSIZE1:  misaligned = 1'b0;
      MSIZE2:  misaligned = addr_off[0];
      MSIZE4:  misaligned = |addr_off[1:0];
      default: misaligned = |addr_off;
    endcase
  end

  // Truncate the shifted read data to the access size, then sign/zero-extend.
  // A double-word load already fills the register, so memUnsigned has no effect.
  always_comb begin
    load_result = shifted;
    case (size)
      MSIZE1: load_result = is_unsigned ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                        : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      MSIZE2: load_result = is_unsigned ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                        : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      MSIZE4: load_result = is_unsigned ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                        : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      default: load_result = shifted;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: MEM stage of the RV64 core. Accepts the execute bundle,
// issues at most one data-bus access per instruction, waits for data_ok,
// and hands a registered bundle to writeback over a valid/ready handshake.
module memory_stage
  import memory_stage_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  execute_data_t dataE,
  output logic          out_valid,
  input  logic          out_ready,
  output memory_data_t  dataM,
  output dbus_req_t     dreq,
  input  dbus_resp_t    dresp
);

  mem_state_t    state_q, state_d;
  execute_data_t req_q, req_d;         // instruction held while its bus access is open
  memory_data_t  data_m_q, data_m_d;   // bundle presented to writeback

  execute_data_t align_src;
  logic          accept;
  logic          is_mem_op;
  strobe_t       al_strobe;
  word_t         al_wdata;
  word_t         al_load;
  logic          al_misaligned;
  logic          unused_addr_ok;

  // The bus acknowledges completion with data_ok only; address acceptance is not tracked.
  assign unused_addr_ok = dresp.addr_ok;

  // Handshake: a new instruction enters when idle or when the finished one leaves.
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign dataM     = data_m_q;
  assign is_mem_op = dataE.ctl.memRead || dataE.ctl.memWrite;

  // While an access is open the aligner works on the held request (stable
  // dreq fields, load formatting); otherwise it screens the incoming one.
  assign align_src = (state_q == REQ) ? req_q : dataE;

  mem_align u_align (
    .addr_off    (align_src.alu_out[2:0]),
    .size        (align_src.ctl.memSize),
    .is_unsigned (align_src.ctl.memUnsigned),
    .storedata   (align_src.storedata),
    .rdata       (dresp.data),
    .strobe      (al_strobe),
    .wdata       (al_wdata),
    .load_result (al_load),
    .misaligned  (al_misaligned)
  );

  // Build the writeback bundle from an execute bundle plus result/flag.
  function automatic memory_data_t make_out(input execute_data_t e,
                                            input word_t         result,
                                            input logic          misaligned);
    memory_data_t m;
    m.alu_out    = e.alu_out;
    m.pc         = e.pc;
    m.sextimm    = e.sextimm;
    m.rd         = result;
    m.dst        = e.rd;
    m.ctl        = e.ctl;
    m.misaligned = misaligned;
    return m;
  endfunction

  // Next-state and datapath update for the IDLE/REQ/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    data_m_d = data_m_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          req_d = dataE;
          if (!is_mem_op) begin
            state_d  = DONE;
            data_m_d = make_out(dataE, '0, 1'b0);
          end else if (al_misaligned) begin
            // Misaligned accesses never reach the bus.
            state_d  = DONE;
            data_m_d = make_out(dataE, '0, 1'b1);
          end else begin
            state_d = REQ;
          end
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (dresp.data_ok) begin
          state_d  = DONE;
          data_m_d = make_out(req_q, req_q.ctl.memRead ? al_load : '0, 1'b0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus request: driven only in REQ, straight from the held instruction.
  always_comb begin
    dreq = '0;
    if (state_q == REQ) begin
      dreq.valid = 1'b1;
      dreq.addr  = req_q.alu_out;
      dreq.size  = req_q.ctl.memSize;
      if (req_q.ctl.memWrite) begin
        dreq.strobe = al_strobe;
        dreq.data   = al_wdata;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q  <= IDLE;
      req_q    <= '0;
      data_m_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      data_m_q <= data_m_d;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed cases plus randomized
// instructions compared against an arithmetic reference model.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  execute_data_t dataE;
  logic          out_valid;
  logic          out_ready;
  memory_data_t  dataM;
  dbus_req_t     dreq;
  dbus_resp_t    dresp;

  int        compared   = 0;
  int        mismatched = 0;
  dbus_req_t last_req;

  memory_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dataE     (dataE),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dataM     (dataM),
    .dreq      (dreq),
    .dresp     (dresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic execute_data_t rand_op(input int kind, input bit align);
    execute_data_t e;
    e.alu_out         = {$urandom, $urandom};
    e.pc              = {$urandom, $urandom};
    e.sextimm         = {$urandom, $urandom};
    e.storedata       = {$urandom, $urandom};
    e.rd              = 5'($urandom);
    e.ctl.regWrite    = 1'($urandom);
    e.ctl.memSize     = msize_t'($urandom_range(0, 3));
    e.ctl.memUnsigned = 1'($urandom);
    e.ctl.memRead     = (kind == 1);
    e.ctl.memWrite    = (kind == 2);
    if (align) e.alu_out = e.alu_out & ~(64'(1 << int'(e.ctl.memSize)) - 64'd1);
    return e;
  endfunction

  function automatic dbus_req_t model_req(input execute_data_t e);
    dbus_req_t r;
    int nb;
    int off;
    nb  = 1 << int'(e.ctl.memSize);
    off = int'(e.alu_out % 64'd8);
    r = '0;
    r.valid = 1'b1;
    r.addr  = e.alu_out;
    r.size  = e.ctl.memSize;
    if (e.ctl.memWrite) begin
      r.strobe = 8'(((1 << nb) - 1) << off);
      r.data   = e.storedata << (8 * off);
    end
    return r;
  endfunction

  function automatic memory_data_t model_out(input execute_data_t e, input logic [63:0] rdata);
    memory_data_t m;
    int nb;
    int off;
    bit is_mem;
    bit mis;
    logic [63:0] tmp;
    logic [63:0] mask;
    nb     = 1 << int'(e.ctl.memSize);
    off    = int'(e.alu_out % 64'd8);
    is_mem = e.ctl.memRead || e.ctl.memWrite;
    mis    = is_mem && ((e.alu_out % 64'(nb)) != 64'd0);
    m.alu_out    = e.alu_out;
    m.pc         = e.pc;
    m.sextimm    = e.sextimm;
    m.dst        = e.rd;
    m.ctl        = e.ctl;
    m.misaligned = mis;
    m.rd         = '0;
    if (e.ctl.memRead && !mis) begin
      tmp = rdata >> (8 * off);
      if (nb < 8) begin
        mask = (64'd1 << (8 * nb)) - 64'd1;
        tmp  = tmp & mask;
        if (!e.ctl.memUnsigned && tmp[8*nb-1]) tmp = tmp | ~mask;
      end
      m.rd = tmp;
    end
    return m;
  endfunction

  // ---------------- transaction driver ----------------
  // Issues one instruction from IDLE, answers the bus after lat request
  // cycles, optionally stalls writeback, and checks everything seen.
  task automatic run_op(input string name, input execute_data_t e, input int lat,
                        input logic [63:0] rdata, input int stall);
    memory_data_t exp_m;
    dbus_req_t    exp_r;
    int cyc;
    int vcnt;
    int exp_v;
    bit done;
    exp_m = model_out(e, rdata);
    exp_r = model_req(e);
    exp_v = ((e.ctl.memRead || e.ctl.memWrite) && !exp_m.misaligned) ? lat : 0;
    last_req  = '0;
    dataE     = e;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    dresp     = '0;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL %s in_ready_idle: got %b expected 1", name, in_ready);
    end
    tick();
    in_valid = 1'b0;
    dataE    = rand_op(0, 0);
    cyc = 1; vcnt = 0; done = 0;
    while (!done && cyc <= 30) begin
      if (out_valid === 1'b1) begin
        done = 1;
      end else begin
        if (dreq.valid === 1'b1) begin
          vcnt++;
          dresp.addr_ok = 1'b1;
          dresp.data_ok = (vcnt >= lat);
          dresp.data    = rdata;
          #1;
          compared++;
          if (dreq !== exp_r) begin
            mismatched++;
            $display("FAIL %s dreq: got %h expected %h", name, dreq, exp_r);
          end
          last_req = dreq;
        end
        tick();
        dresp = '0;
        cyc++;
      end
    end
    compared++;
    if (!done) begin
      mismatched++;
      $display("FAIL %s out_valid_timeout: got none expected out_valid within 30 cycles", name);
      return;
    end
    compared++;
    if (cyc != exp_v + 1) begin
      mismatched++;
      $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp_v + 1);
    end
    compared++;
    if (vcnt != exp_v) begin
      mismatched++;
      $display("FAIL %s dreq_valid_cycles: got %0d expected %0d", name, vcnt, exp_v);
    end
    compared++;
    if (dataM !== exp_m) begin
      mismatched++;
      $display("FAIL %s dataM: got %h expected %h", name, dataM, exp_m);
    end
    // Writeback stall; a stray data_ok must not disturb the held result.
    for (int i = 0; i < stall; i++) begin
      dresp.data_ok = 1'b1;
      dresp.data    = {$urandom, $urandom};
      #1;
      compared++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || dataM !== exp_m || dreq.valid !== 1'b0) begin
        mismatched++;
        $display("FAIL %s stall%0d: got in_ready=%b out_valid=%b dreq.valid=%b dataM=%h expected 0/1/0 %h",
                 name, i, in_ready, out_valid, dreq.valid, dataM, exp_m);
      end
      tick();
    end
    dresp     = '0;
    out_ready = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL %s in_ready_done: got %b expected 1", name, in_ready);
    end
    tick();
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL %s back_to_idle: got out_valid=%b expected 0", name, out_valid);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dresp = '0; dataE = rand_op(1, 1);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    compared++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dreq !== '0 || dataM !== '0) begin
      mismatched++;
      $display("FAIL reset_state: got out_valid=%b in_ready=%b dreq=%h dataM=%h expected 0/1/0/0",
               out_valid, in_ready, dreq, dataM);
    end
  endtask

  task automatic test_alu();
    for (int i = 0; i < 6; i++) run_op("alu", rand_op(0, 0), 1, '0, 0);
  endtask

  task automatic test_directed();
    execute_data_t e;
    e = rand_op(1, 1);
    e.alu_out = 64'h1003; e.ctl.memSize = MSIZE1; e.ctl.memUnsigned = 1'b0;
    run_op("lb", e, 3, 64'h0000_0000_8000_0000, 0);
    compared++;
    if (dataM.rd !== 64'hFFFF_FFFF_FFFF_FF80 || last_req.strobe !== 8'h00) begin
      mismatched++;
      $display("FAIL lb_result: got rd=%h strobe=%h expected ffffffffffffff80 00", dataM.rd, last_req.strobe);
    end
    e.ctl.memUnsigned = 1'b1;
    run_op("lbu", e, 3, 64'h0000_0000_8000_0000, 0);
    compared++;
    if (dataM.rd !== 64'h80) begin
      mismatched++;
      $display("FAIL lbu_result: got %h expected 80", dataM.rd);
    end
    e = rand_op(2, 1);
    e.alu_out = 64'h2006; e.ctl.memSize = MSIZE2; e.storedata = 64'hBEEF;
    run_op("sh", e, 2, {$urandom, $urandom}, 0);
    compared++;
    if (last_req.strobe !== 8'hC0 || last_req.data !== 64'hBEEF_0000_0000_0000 || dataM.rd !== 64'd0) begin
      mismatched++;
      $display("FAIL sh_bus: got strobe=%h data=%h rd=%h expected c0 beef000000000000 0",
               last_req.strobe, last_req.data, dataM.rd);
    end
    e = rand_op(1, 1);
    e.alu_out = 64'h3002; e.ctl.memSize = MSIZE4;
    run_op("lw_misaligned", e, 2, {$urandom, $urandom}, 0);
    compared++;
    if (dataM.misaligned !== 1'b1 || dataM.rd !== 64'd0) begin
      mismatched++;
      $display("FAIL lw_misaligned_flag: got misaligned=%b rd=%h expected 1 0", dataM.misaligned, dataM.rd);
    end
  endtask

  task automatic test_back_to_back();
    execute_data_t e1, e2;
    logic [63:0] r1, r2;
    e1 = rand_op(1, 1); e2 = rand_op(1, 1);
    r1 = {$urandom, $urandom}; r2 = {$urandom, $urandom};
    out_ready = 1'b1; dataE = e1; in_valid = 1'b1; dresp = '0;
    tick();                                   // e1 accepted
    dataE = e2; dresp.data_ok = 1'b1; dresp.data = r1;
    #1;
    compared++;
    if (dreq !== model_req(e1) || in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_req1: got dreq=%h in_ready=%b expected %h 0", dreq, in_ready, model_req(e1));
    end
    tick();                                   // e1 done
    dresp = '0;
    compared++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || dataM !== model_out(e1, r1)) begin
      mismatched++;
      $display("FAIL b2b_out1: got out_valid=%b in_ready=%b dataM=%h expected 1 1 %h",
               out_valid, in_ready, dataM, model_out(e1, r1));
    end
    tick();                                   // e2 accepted straight from DONE
    in_valid = 1'b0; dresp.data_ok = 1'b1; dresp.data = r2;
    #1;
    compared++;
    if (out_valid !== 1'b0 || dreq !== model_req(e2)) begin
      mismatched++;
      $display("FAIL b2b_req2: got out_valid=%b dreq=%h expected 0 %h", out_valid, dreq, model_req(e2));
    end
    tick();                                   // e2 done
    dresp = '0;
    compared++;
    if (out_valid !== 1'b1 || dataM !== model_out(e2, r2)) begin
      mismatched++;
      $display("FAIL b2b_out2: got out_valid=%b dataM=%h expected 1 %h", out_valid, dataM, model_out(e2, r2));
    end
    tick();
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_idle: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_stall();
    run_op("stall_load", rand_op(1, 1), 2, {$urandom, $urandom}, 4);
    run_op("stall_alu", rand_op(0, 0), 1, '0, 4);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op("random", rand_op($urandom_range(0, 2), $urandom_range(0, 3) != 0),
             $urandom_range(1, 4), {$urandom, $urandom}, $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid();
    dataE = rand_op(1, 1); in_valid = 1'b1; out_ready = 1'b1; dresp = '0;
    tick();
    in_valid = 1'b0;
    compared++;
    if (dreq.valid !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_mid_req: got dreq.valid=%b expected 1", dreq.valid);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    compared++;
    if (dreq.valid !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_mid_idle: got dreq.valid=%b out_valid=%b in_ready=%b expected 0 0 1",
               dreq.valid, out_valid, in_ready);
    end
    for (int i = 0; i < 2; i++) begin
      dresp.data_ok = 1'b1; dresp.data = {$urandom, $urandom};
      tick();
      compared++;
      if (out_valid !== 1'b0 || dataM !== '0 || dreq.valid !== 1'b0) begin
        mismatched++;
        $display("FAIL rst_mid_stale%0d: got out_valid=%b dreq.valid=%b dataM=%h expected 0 0 0",
                 i, out_valid, dreq.valid, dataM);
      end
    end
    dresp = '0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_directed();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
